// File: rtl/i2c_slave_write_receiver.sv
// Byte-level I2C slave receive engine: matches its own address for writes,
// ACKs every data byte and hands each completed byte out with a one-cycle valid.
module i2c_slave_write_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       synced_sda_input,
  input  logic       synced_scl_input,
  input  logic       communication_initiated,
  output logic       is_communicating,
  output logic       sda_drive_low,
  output logic       addr_match,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_scl_q;
  logic       r_sda_q;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic       r_ack_drive;
  logic       w_ack_drive_next;
  logic       w_load;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_stop;
  logic       w_rstart;
  logic [7:0] w_shifted;

  assign w_scl_rise = synced_scl_input & ~r_scl_q;
  assign w_scl_fall = ~synced_scl_input & r_scl_q;
  assign w_stop     = synced_sda_input & ~r_sda_q & synced_scl_input & r_scl_q;
  assign w_rstart   = ~synced_sda_input & r_sda_q & synced_scl_input & r_scl_q;
  assign w_shifted  = {r_shift[6:0], synced_sda_input};

  // Line history resets to the idle-bus level so no edge is seen out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_scl_q     <= 1'b1;
      r_sda_q     <= 1'b1;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_ack_drive <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_scl_q     <= synced_scl_input;
      r_sda_q     <= synced_sda_input;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_ack_drive <= w_ack_drive_next;
      r_rx_valid  <= w_load;
      if (w_load) begin
        r_rx_data <= w_shift_next;
      end
    end
  end

  // Bus conditions outrank SCL edges; r_ack_drive tracks the two-fall ACK slot.
  always_comb begin
    w_next_state     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_ack_drive_next = r_ack_drive;
    w_load           = 1'b0;
    if (r_state == S_IDLE) begin
      if (communication_initiated) begin
        w_next_state     = S_ADDR;
        w_bit_cnt_next   = 3'd0;
        w_shift_next     = 8'h00;
        w_ack_drive_next = 1'b0;
      end
    end else if (w_stop) begin
      w_next_state     = S_IDLE;
      w_bit_cnt_next   = 3'd0;
      w_shift_next     = 8'h00;
      w_ack_drive_next = 1'b0;
    end else if (w_rstart) begin
      w_next_state     = S_ADDR;
      w_bit_cnt_next   = 3'd0;
      w_shift_next     = 8'h00;
      w_ack_drive_next = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_next   = w_shifted;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_next_state = (w_shifted == {SLAVE_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_drive) begin
              w_ack_drive_next = 1'b1;
            end else begin
              w_ack_drive_next = 1'b0;
              w_bit_cnt_next   = 3'd0;
              w_next_state     = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_scl_rise) begin
            w_shift_next   = w_shifted;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_load       = 1'b1;
              w_next_state = S_DATA_ACK;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Only matched write transfers reach the ACK/DATA states, so state alone gives addr_match.
  always_comb begin
    is_communicating = (r_state != S_IDLE);
    addr_match       = (r_state == S_ADDR_ACK) || (r_state == S_DATA) ||
                       (r_state == S_DATA_ACK);
    sda_drive_low    = r_ack_drive &&
                       ((r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK));
    rx_data          = r_rx_data;
    rx_valid         = r_rx_valid;
  end

endmodule

// File: tb/tb_i2c_slave_write_receiver.sv
// Bench for the I2C slave write receiver: bit-level bus master, received-byte
// monitor, a vector table, random transfers against a transfer-level model.
module tb_i2c_slave_write_receiver;

  localparam int H = 4;
  localparam logic [6:0] ADDR = 7'h42;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       mSda;
  logic       communication_initiated;
  logic       sdaLine;
  logic       is_communicating;
  logic       sda_drive_low;
  logic       addr_match;
  logic [7:0] rx_data;
  logic       rx_valid;

  int errors = 0;
  int checks = 0;
  logic [7:0] gotQ[$];
  int pulseCycles = 0;
  int driveCycles = 0;

  // Open-drain bus: the slave's ACK pulls the shared line low.
  assign sdaLine = mSda & ~sda_drive_low;

  i2c_slave_write_receiver #(.SLAVE_ADDR(ADDR)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .synced_sda_input        (sdaLine),
    .synced_scl_input        (scl),
    .communication_initiated (communication_initiated),
    .is_communicating        (is_communicating),
    .sda_drive_low           (sda_drive_low),
    .addr_match              (addr_match),
    .rx_data                 (rx_data),
    .rx_valid                (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      gotQ.push_back(rx_data);
      pulseCycles++;
    end
    if (sda_drive_low === 1'b1) driveCycles++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [2:0]  nBytes;
    logic [31:0] data;
    logic        expAck;
    logic [2:0]  expRx;
  } vec_t;

  vec_t vecs[6];

  function automatic logic modelAccepts(input logic [7:0] a);
    return (a[7:1] == ADDR) && (a[0] == 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic sclV, input logic sdaV, input int cycles);
    scl  = sclV;
    mSda = sdaV;
    waitCycles(cycles);
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, b, H);
    applyStimulus(1'b1, b, H);
    applyStimulus(1'b0, b, 1);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  task automatic busStart();
    applyStimulus(1'b1, 1'b0, 1);
    communication_initiated = 1'b1;
    waitCycles(1);
    communication_initiated = 1'b0;
    applyStimulus(1'b1, 1'b0, H);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  task automatic busStop();
    applyStimulus(1'b0, 1'b0, H);
    applyStimulus(1'b1, 1'b0, H);
    applyStimulus(1'b1, 1'b1, H);
  endtask

  task automatic busRstart();
    applyStimulus(1'b0, 1'b1, H);
    applyStimulus(1'b1, 1'b1, H);
    applyStimulus(1'b1, 1'b0, H);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  // Ninth clock: master releases SDA, slave ACK is sampled mid-high.
  task automatic ackClock(input logic expAck, input string name);
    applyStimulus(1'b0, 1'b1, H);
    applyStimulus(1'b1, 1'b1, H / 2);
    checkOutput({name, " ack"}, {31'd0, sda_drive_low}, {31'd0, expAck});
    checkOutput({name, " addr_match"}, {31'd0, addr_match}, {31'd0, expAck});
    waitCycles(H - H / 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput({name, " release"}, {31'd0, sda_drive_low}, 32'd0);
  endtask

  task automatic checkReceived(input string name, input logic [31:0] data,
                               input int expRx);
    checkOutput({name, " rx count"}, gotQ.size(), expRx);
    checkOutput({name, " rx pulse cycles"}, pulseCycles, expRx);
    for (int i = 0; i < expRx && gotQ.size() > 0; i++) begin
      checkOutput({name, " rx byte"}, {24'd0, gotQ.pop_front()},
                  {24'd0, data[31 - 8 * i -: 8]});
    end
  endtask

  task automatic runTransfer(input logic [7:0] a, input int n, input logic [31:0] data,
                             input logic expAck, input int expRx, input string name);
    gotQ.delete();
    pulseCycles = 0;
    driveCycles = 0;
    busStart();
    checkOutput({name, " is_communicating"}, {31'd0, is_communicating}, 32'd1);
    sendByte(a);
    ackClock(expAck, {name, " addr"});
    for (int i = 0; i < n; i++) begin
      sendByte(data[31 - 8 * i -: 8]);
      ackClock(expAck, {name, " data"});
    end
    busStop();
    checkOutput({name, " idle after stop"}, {31'd0, is_communicating}, 32'd0);
    checkOutput({name, " match after stop"}, {31'd0, addr_match}, 32'd0);
    if (!expAck) checkOutput({name, " never drives"}, driveCycles, 32'd0);
    checkReceived(name, data, expRx);
  endtask

  initial begin
    logic [7:0]  ra;
    int          rn;
    logic [31:0] rd;

    vecs[0] = '{addr: 8'h84, nBytes: 3'd1, data: 32'hA500_0000, expAck: 1'b1, expRx: 3'd1};
    vecs[1] = '{addr: 8'h86, nBytes: 3'd1, data: 32'hFF00_0000, expAck: 1'b0, expRx: 3'd0};
    vecs[2] = '{addr: 8'h85, nBytes: 3'd1, data: 32'h5500_0000, expAck: 1'b0, expRx: 3'd0};
    vecs[3] = '{addr: 8'h84, nBytes: 3'd2, data: 32'h1122_0000, expAck: 1'b1, expRx: 3'd2};
    vecs[4] = '{addr: 8'h04, nBytes: 3'd1, data: 32'h7700_0000, expAck: 1'b0, expRx: 3'd0};
    vecs[5] = '{addr: 8'h84, nBytes: 3'd4, data: 32'h00FF_8001, expAck: 1'b1, expRx: 3'd4};

    rst = 1'b1;
    scl = 1'b1;
    mSda = 1'b1;
    communication_initiated = 1'b0;
    waitCycles(3);
    checkOutput("reset is_communicating", {31'd0, is_communicating}, 32'd0);
    checkOutput("reset sda_drive_low", {31'd0, sda_drive_low}, 32'd0);
    checkOutput("reset addr_match", {31'd0, addr_match}, 32'd0);
    checkOutput("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    waitCycles(2);

    for (int v = 0; v < 6; v++) begin
      runTransfer(vecs[v].addr, int'(vecs[v].nBytes), vecs[v].data,
                  vecs[v].expAck, int'(vecs[v].expRx), $sformatf("vec%0d", v));
    end

    // Multi-byte write with a repeated start in the middle.
    gotQ.delete();
    pulseCycles = 0;
    busStart();
    sendByte(8'h84);
    ackClock(1'b1, "rs addr1");
    sendByte(8'h11);
    ackClock(1'b1, "rs d11");
    sendByte(8'h22);
    ackClock(1'b1, "rs d22");
    busRstart();
    checkOutput("rs is_communicating held", {31'd0, is_communicating}, 32'd1);
    checkOutput("rs match cleared", {31'd0, addr_match}, 32'd0);
    sendByte(8'h84);
    ackClock(1'b1, "rs addr2");
    sendByte(8'h33);
    ackClock(1'b1, "rs d33");
    busStop();
    checkOutput("rs idle after stop", {31'd0, is_communicating}, 32'd0);
    checkReceived("rs", 32'h1122_3300, 3);

    // Stop after four data bits discards the partial byte.
    gotQ.delete();
    pulseCycles = 0;
    busStart();
    sendByte(8'h84);
    ackClock(1'b1, "mid addr");
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    busStop();
    checkOutput("mid idle", {31'd0, is_communicating}, 32'd0);
    checkReceived("mid partial", 32'd0, 0);
    runTransfer(8'h84, 1, 32'h5A00_0000, 1'b1, 1, "after mid");

    // Reset asserted while the data-byte ACK is being driven.
    gotQ.delete();
    busStart();
    sendByte(8'h84);
    ackClock(1'b1, "rst addr");
    sendByte(8'hC3);
    applyStimulus(1'b0, 1'b1, H);
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("rst pre ack", {31'd0, sda_drive_low}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst sda released", {31'd0, sda_drive_low}, 32'd0);
    checkOutput("rst is_communicating", {31'd0, is_communicating}, 32'd0);
    checkOutput("rst addr_match", {31'd0, addr_match}, 32'd0);
    checkOutput("rst rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst rx_data", {24'd0, rx_data}, 32'd0);
    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("rst idle after release", {31'd0, is_communicating}, 32'd0);
    runTransfer(8'h84, 1, 32'h3C00_0000, 1'b1, 1, "after rst");

    // Random transfers checked against the transfer-level model.
    for (int t = 0; t < 12; t++) begin
      ra = ($urandom_range(0, 1) == 1) ? 8'h84 : 8'($urandom_range(0, 255));
      rn = int'($urandom_range(0, 3));
      rd = $urandom;
      runTransfer(ra, rn, rd, modelAccepts(ra), modelAccepts(ra) ? rn : 0,
                  $sformatf("rand%0d a=%02h", t, ra));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
